// File: rtl/input_line_streamer_if.sv
// input_line_streamer_if
//   Output stream bundle of one input_line_streamer channel.
//   master : streamer side  (drives out_valid/out_pos/out_val/out_last, samples out_ready)
//   slave  : consumer side  (samples entry signals, drives out_ready)
//   out_valid  entry on out_pos/out_val is valid
//   out_ready  consumer accepts the entry
//   out_pos    absolute position (running sum of deltas)
//   out_val    entry value
//   out_last   entry is the final one of the line
interface input_line_streamer_if #(
  parameter int unsigned POS_W = 8,
  parameter int unsigned VAL_W = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [POS_W-1:0] out_pos;
  logic [VAL_W-1:0] out_val;
  logic             out_last;

  modport master (output out_valid, output out_pos, output out_val, output out_last,
                  input  out_ready);
  modport slave  (input  out_valid, input  out_pos, input  out_val, input  out_last,
                  output out_ready);
endinterface

// File: rtl/input_line_streamer.sv
// input_line_streamer
//   Holds one input line of delta-encoded {delta, value} entries and streams them
//   to the APE array with absolute positions (running sum of deltas, mod 2^POS_W).
//   One entry per two cycles; line_finished is high whenever the channel is idle.
// Ports
//   clock, reset     clock; synchronous active-high reset
//   wr_en/wr_addr/wr_data  buffer write, accepted only while idle
//   wr_drop          combinational pulse: current write ignored (busy)
//   line_len         entry count, sampled with an accepted in_line_start
//   in_line_start    one-cycle start pulse
//   line_finished    level: line done / idle
//   out_if           output stream (master modport)
module input_line_streamer #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned DELTA_W = 4,
  parameter int unsigned VAL_W   = 8,
  parameter int unsigned POS_W   = 8,
  parameter int unsigned LEN_W   = $clog2(DEPTH + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DELTA_W+VAL_W-1:0]   wr_data,
  output logic                       wr_drop,
  input  logic [LEN_W-1:0]           line_len,
  input  logic                       in_line_start,
  output logic                       line_finished,
  input_line_streamer_if.master      out_if
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

  state_t state_q, state_d;

  logic [DELTA_W+VAL_W-1:0] mem [DEPTH];
  logic [DELTA_W+VAL_W-1:0] rd_entry;

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [POS_W-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [POS_W-1:0] out_pos_q, out_pos_d;
  logic [VAL_W-1:0] out_val_q, out_val_d;
  logic             out_last_q, out_last_d;
  logic             line_finished_q, line_finished_d;

  logic wr_accept;
  logic handshake;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_line_start && line_len != '0) state_d = FETCH;
      FETCH:   state_d = STREAM;
      STREAM:  if (out_if.out_ready) state_d = out_last_q ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    wr_accept = wr_en && (state_q == IDLE);
    wr_drop   = wr_en && (state_q != IDLE);
    handshake = (state_q == STREAM) && out_valid_q && out_if.out_ready;
  end

  always_ff @(posedge clock) begin
    if (wr_accept) mem[wr_addr] <= wr_data;
  end

  // Write and read use the same edge ordering: a write accepted together with a
  // start has landed before the FETCH cycle reads the array.
  assign rd_entry = mem[rd_ptr_q];

  // The out_* registers double as the read-data register of the synchronous
  // read, so they hold their value across stalls and after the handshake.
  always_comb begin
    rd_ptr_d        = rd_ptr_q;
    len_d           = len_q;
    acc_d           = acc_q;
    out_valid_d     = out_valid_q;
    out_pos_d       = out_pos_q;
    out_val_d       = out_val_q;
    out_last_d      = out_last_q;
    line_finished_d = line_finished_q;
    unique case (state_q)
      IDLE: begin
        line_finished_d = 1'b1;
        if (in_line_start) begin
          len_d           = (line_len > DEPTH_LEN) ? DEPTH_LEN : line_len;
          acc_d           = '0;
          rd_ptr_d        = '0;
          line_finished_d = 1'b0;
        end
      end
      FETCH: begin
        out_valid_d = 1'b1;
        out_pos_d   = acc_q + POS_W'(rd_entry[VAL_W +: DELTA_W]);
        out_val_d   = rd_entry[VAL_W-1:0];
        out_last_d  = (LEN_W'(rd_ptr_q) == len_q - LEN_W'(1));
      end
      STREAM: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          acc_d       = out_pos_q;
          if (out_last_q) line_finished_d = 1'b1;
          else            rd_ptr_d        = rd_ptr_q + AW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q        <= '0;
      len_q           <= '0;
      acc_q           <= '0;
      out_valid_q     <= 1'b0;
      out_pos_q       <= '0;
      out_val_q       <= '0;
      out_last_q      <= 1'b0;
      line_finished_q <= 1'b1;
    end else begin
      rd_ptr_q        <= rd_ptr_d;
      len_q           <= len_d;
      acc_q           <= acc_d;
      out_valid_q     <= out_valid_d;
      out_pos_q       <= out_pos_d;
      out_val_q       <= out_val_d;
      out_last_q      <= out_last_d;
      line_finished_q <= line_finished_d;
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_pos   = out_pos_q;
  assign out_if.out_val   = out_val_q;
  assign out_if.out_last  = out_last_q;
  assign line_finished    = line_finished_q;

endmodule
